// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults, width helpers and status type for the
//                parametrised single-clock FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  // Occupancy counter must hold the value DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses entries 0..depth-1; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                registered read port with read enable. Array is not reset;
//                only the read register is.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [PW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [PW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; holds its last value when no read is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO with registered flags,
//                occupancy count, almost-full/empty thresholds, synchronous
//                flush and sticky overflow/underflow.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  AF_LEVEL = 28,
  parameter int  AE_LEVEL = 4,
  localparam int CW       = cnt_width(DEPTH),
  localparam int PW       = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_op,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  // Parameter range checks, evaluated at elaboration.
  if (WIDTH < 1) begin : g_chk_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_chk_order
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF       = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_AE       = CW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  fifo_status_t  status_q, status_d;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q,   overflow_d;
  logic          underflow_q,  underflow_d;
  logic          w_wr_acc, w_rd_acc;

  // Explicit wrap compare keeps pointers in 0..DEPTH-1 for any DEPTH.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == c_LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Acceptance from registered flags, next-state pointers/count/flags/errors.
  always_comb begin
    w_wr_acc     = wr_en & ~status_q.full  & ~flush;
    w_rd_acc     = rd_en & ~status_q.empty & ~flush;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = w_rd_acc;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (w_rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(w_wr_acc) - CW'(w_rd_acc);
    end

    // Flags follow the post-access occupancy so they are never a cycle late.
    status_d.full         = (count_d == c_DEPTH);
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= c_AF);
    status_d.almost_empty = (count_d <= c_AE);

    // A new error in the same cycle as clr_err wins; flush ignores requests.
    overflow_d  = (wr_en & status_q.full  & ~flush) | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & status_q.empty & ~flush) | (underflow_q & ~clr_err);
  end

  // Control state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q              <= '0;
      rd_ptr_q              <= '0;
      count_q               <= '0;
      status_q.full         <= 1'b0;
      status_q.empty        <= 1'b1;
      status_q.almost_full  <= 1'b0;
      status_q.almost_empty <= 1'b1;
      data_valid_q          <= 1'b0;
      overflow_q            <= 1'b0;
      underflow_q           <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      status_q     <= status_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (w_wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (w_rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_op)
  );

  assign data_valid   = data_valid_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Self-checking bench for sync_fifo_param: directed scenarios
//                plus randomized traffic against a queue-based model, and a
//                small DEPTH=5 instance for pointer wrap ordering.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;
  localparam int CW = 6;
  localparam int WB = 8;
  localparam int DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, wr_en, rd_en, clr_err;
  logic [W-1:0]  data_in, data_op;
  logic          data_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  logic          wr_en_b, rd_en_b, flush_b, clr_err_b;
  logic [WB-1:0] data_in_b, data_op_b;
  logic          data_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [2:0]    count_b;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_op(data_op), .data_valid(data_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.WIDTH(WB), .DEPTH(DB), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .wr_en(wr_en_b), .data_in(data_in_b),
    .rd_en(rd_en_b), .data_op(data_op_b), .data_valid(data_valid_b), .full(full_b),
    .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b), .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_err_b)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, plus output/error state.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_data;
  logic         m_dv, m_ovf, m_unf;

  task automatic model_reset();
    mq.delete();
    m_data = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    bit was_full, was_empty;
    n         = mq.size();
    was_full  = (n == D);
    was_empty = (n == 0);
    if (flush) begin
      mq.delete();
      m_dv = 1'b0;
    end else begin
      m_dv = rd_en && !was_empty;
      if (m_dv) m_data = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(data_in);
    end
    if (!flush && wr_en && was_full) m_ovf = 1'b1;
    else if (clr_err)                m_ovf = 1'b0;
    if (!flush && rd_en && was_empty) m_unf = 1'b1;
    else if (clr_err)                 m_unf = 1'b0;
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == D));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("data_valid",   32'(data_valid),   32'(m_dv));
    chk("data_op",      data_op,           m_data);
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    wr_en_b = 1'b0; rd_en_b = 1'b0; flush_b = 1'b0; clr_err_b = 1'b0; data_in_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Fill 0..31, almost_full from count 28, full after the 32nd write.
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 1'b0, W'(i));
      step();
      if (i == 26) chk("af_below", 32'(almost_full), 32'd0);
      if (i == 27) chk("af_at_28", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd32);
    // Drain: values in order with one clock of latency.
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 1'b1, '0);
      step();
      chk("drain_data", data_op, 32'(i));
      chk("drain_dv", 32'(data_valid), 32'd1);
    end
    drive(1'b0, 1'b0, '0);
    step();
    chk("hold_data", data_op, 32'd31);
    chk("hold_dv", 32'(data_valid), 32'd0);

    // Simultaneous read/write at a steady occupancy.
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b0, $urandom); step(); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, $urandom);
      step();
      chk("simul_count", 32'(count), 32'd10);
    end
    for (int i = 0; i < 22; i++) begin drive(1'b1, 1'b0, $urandom); step(); end
    drive(1'b1, 1'b1, $urandom);
    step();
    chk("full_both_count", 32'(count), 32'd31);
    chk("full_both_ovf", 32'(overflow), 32'd1);
    drive(1'b0, 1'b0, '0); clr_err = 1'b1; step();
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 31; i++) begin drive(1'b0, 1'b1, '0); step(); end
    drive(1'b1, 1'b1, 32'hA5A5_0001);
    step();
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_unf", 32'(underflow), 32'd1);
    drive(1'b0, 1'b1, '0); step();

    // Overflow keeps contents intact; clr_err racing a new underflow.
    for (int i = 0; i < D; i++) begin drive(1'b1, 1'b0, 32'h100 + W'(i)); step(); end
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    step();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd32);
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 1'b1, '0);
      step();
      chk("ovf_contents", data_op, 32'h100 + 32'(i));
    end
    drive(1'b0, 1'b0, '0); clr_err = 1'b1; step();
    chk("clr_both_ovf", 32'(overflow), 32'd0);
    drive(1'b0, 1'b1, '0); clr_err = 1'b1; step();
    chk("unf_wins_clr", 32'(underflow), 32'd1);

    // Flush at count 17 with a concurrent write; sticky error survives.
    for (int i = 0; i < 17; i++) begin drive(1'b1, 1'b0, $urandom); step(); end
    drive(1'b1, 1'b0, 32'hBEEF_0000); flush = 1'b1;
    step();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_unf", 32'(underflow), 32'd1);
    drive(1'b1, 1'b0, 32'h55); step();
    drive(1'b0, 1'b1, '0); step();
    chk("flush_dropped", data_op, 32'h55);

    // Asynchronous reset mid-stream: outputs clear before the next edge.
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, $urandom); step(); end
    drive(1'b1, 1'b1, $urandom);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_data", data_op, 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    model_reset();
    drive(1'b0, 1'b0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    compare_all();

    // Randomized traffic with alternating fill/drain bias.
    for (int c = 0; c < 2000; c++) begin
      int p;
      p       = ((c / 250) % 2 == 1) ? 30 : 70;
      flush   = ($urandom_range(0, 149) == 0);
      wr_en   = !flush && ($urandom_range(0, 99) < p);
      rd_en   = !flush && ($urandom_range(0, 99) < (100 - p));
      clr_err = ($urandom_range(0, 39) == 0);
      data_in = $urandom;
      step();
    end
    drive(1'b0, 1'b0, '0);

    // DEPTH=5 instance: order preserved across pointer wrap.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        wr_en_b = 1'b1; data_in_b = WB'(r * 3 + k + 1);
        step_b();
      end
      wr_en_b = 1'b0;
      chk("wrap_count", 32'(count_b), 32'd3);
      for (int k = 0; k < 3; k++) begin
        rd_en_b = 1'b1;
        step_b();
        chk("wrap_data", 32'(data_op_b), 32'(r * 3 + k + 1));
      end
      rd_en_b = 1'b0;
      chk("wrap_empty", 32'(empty_b), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
